// File: rtl/wb_register_file_if.sv
// Register-file bus: one write-back port, two ID read ports,
// one debug read port and the committed-write counter.
interface wb_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [ADDR_W-1:0] debugReg;
    logic [DATA_W-1:0] debugData;
    logic [15:0]       writeCount;

    modport master (
        output RegWrite, writeReg, writeData,
        output readReg1, readReg2, debugReg,
        input  readData1, readData2, debugData,
        input  writeCount
    );

    modport slave (
        input  RegWrite, writeReg, writeData,
        input  readReg1, readReg2, debugReg,
        output readData1, readData2, debugData,
        output writeCount
    );
endinterface

// File: rtl/wb_register_file.sv
// MIPS 32x32 general register file, written by WB, read by ID.
// Ports: clk, rst_n (async active-low), bus (slave modport):
//   RegWrite/writeReg/writeData write port, readReg1/2 ->
//   readData1/2 bypassed reads, debugReg -> debugData committed
//   read, writeCount committed-write counter.
module wb_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input logic                clk,
    input logic                rst_n,
    wb_register_file_if.slave  bus
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [15:0]       count;
    logic              we;

    // Writes to r0 are dropped and not counted.
    assign we = bus.RegWrite && (bus.writeReg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            count <= '0;
        end else if (we) begin
            regs[bus.writeReg] <= bus.writeData;
            count              <= count + 16'd1;
        end
    end

    // ID read: r0 is zero, a same-cycle write is forwarded.
    // Outputs are forced to zero while reset is held so a
    // pending write cannot leak through the bypass.
    function automatic logic [DATA_W-1:0] rd_port(
        input logic              rst_ok,
        input logic [ADDR_W-1:0] idx,
        input logic              wen,
        input logic [ADDR_W-1:0] widx,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (!rst_ok || idx == '0) begin
            return '0;
        end else if (wen && widx == idx) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    always_comb begin
        bus.readData1 = rd_port(rst_n, bus.readReg1,
                                bus.RegWrite, bus.writeReg,
                                bus.writeData,
                                regs[bus.readReg1]);
        bus.readData2 = rd_port(rst_n, bus.readReg2,
                                bus.RegWrite, bus.writeReg,
                                bus.writeData,
                                regs[bus.readReg2]);
    end

    // Debug port sees only committed state.
    always_comb begin
        bus.debugData = '0;
        if (rst_n && bus.debugReg != '0) begin
            bus.debugData = regs[bus.debugReg];
        end
    end

    assign bus.writeCount = count;
endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: directed vectors,
// expectations queued by stimulus and checked by a monitor.
module tb_wb_register_file;
    logic clk;
    logic rst_n;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] dbg;
        logic [15:0] wc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    wb_register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_register_file #(
        .DATA_W(32),
        .ADDR_W(5),
        .NREGS(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 4;
            if (bus.readData1 !== e.rd1) begin
                errors++;
                $display("FAIL %s readData1 got %h want %h",
                         e.name, bus.readData1, e.rd1);
            end
            if (bus.readData2 !== e.rd2) begin
                errors++;
                $display("FAIL %s readData2 got %h want %h",
                         e.name, bus.readData2, e.rd2);
            end
            if (bus.debugData !== e.dbg) begin
                errors++;
                $display("FAIL %s debugData got %h want %h",
                         e.name, bus.debugData, e.dbg);
            end
            if (bus.writeCount !== e.wc) begin
                errors++;
                $display("FAIL %s writeCount got %h want %h",
                         e.name, bus.writeCount, e.wc);
            end
        end
    end

    task automatic step(
        input logic        we,
        input logic [4:0]  wr,
        input logic [31:0] wd,
        input logic [4:0]  r1,
        input logic [4:0]  r2,
        input logic [4:0]  dg
    );
        @(posedge clk);
        #1;
        bus.RegWrite  = we;
        bus.writeReg  = wr;
        bus.writeData = wd;
        bus.readReg1  = r1;
        bus.readReg2  = r2;
        bus.debugReg  = dg;
    endtask

    task automatic expect_out(
        input string       nm,
        input logic [31:0] e1,
        input logic [31:0] e2,
        input logic [31:0] ed,
        input logic [15:0] ew
    );
        exp_t e;
        e.name = nm;
        e.rd1  = e1;
        e.rd2  = e2;
        e.dbg  = ed;
        e.wc   = ew;
        exp_q.push_back(e);
    endtask

    initial begin
        int wait_cyc;
        rst_n         = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.writeReg  = '0;
        bus.writeData = '0;
        bus.readReg1  = '0;
        bus.readReg2  = '0;
        bus.debugReg  = '0;

        // Held in reset, even with a write pending.
        step(1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7, 5'd7);
        expect_out("rst_hold", 0, 0, 0, 0);
        step(0, 0, 0, 5'd1, 5'd2, 5'd3);
        expect_out("rst_hold2", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Sweep all indices after release.
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a;
            logic [4:0] b;
            a = 5'(i);
            b = 5'(31 - i);
            step(0, 5'd9, 32'h99999999, a, b, a);
            expect_out("sweep", 0, 0, 0, 0);
        end

        // Basic write: bypass in-cycle, committed next.
        step(1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
        expect_out("wr5_bypass", 32'hDEADBEEF, 0, 0, 0);
        step(0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
        expect_out("wr5_read", 32'hDEADBEEF, 0,
                   32'hDEADBEEF, 16'd1);

        // Same-cycle bypass on both ports.
        step(1, 5'd8, 32'h11111111, 5'd0, 5'd0, 5'd0);
        expect_out("wr8_a", 0, 0, 0, 16'd1);
        step(1, 5'd8, 32'h22222222, 5'd8, 5'd8, 5'd8);
        expect_out("wr8_bypass", 32'h22222222, 32'h22222222,
                   32'h11111111, 16'd2);
        step(0, 5'd8, 32'h33333333, 5'd8, 5'd8, 5'd8);
        expect_out("wr8_after", 32'h22222222, 32'h22222222,
                   32'h22222222, 16'd3);

        // RegWrite=0 never bypasses.
        step(0, 5'd5, 32'h0BAD0BAD, 5'd5, 5'd8, 5'd5);
        expect_out("nowr_nobyp", 32'hDEADBEEF, 32'h22222222,
                   32'hDEADBEEF, 16'd3);

        // Register 0 is hardwired.
        step(1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        expect_out("r0_during", 0, 0, 0, 16'd3);
        step(0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_out("r0_after", 0, 0, 0, 16'd3);

        // Async reset in the middle of a write.
        step(1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd0);
        step(0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
        expect_out("r3_set", 32'hA5A5A5A5, 32'hA5A5A5A5,
                   32'hA5A5A5A5, 16'd4);
        step(1, 5'd3, 32'h12345678, 5'd3, 5'd3, 5'd3);
        rst_n = 1'b0;
        expect_out("rst_mid", 0, 0, 0, 0);
        step(1, 5'd3, 32'h12345678, 5'd3, 5'd3, 5'd3);
        expect_out("rst_mid_edge", 0, 0, 0, 0);
        step(0, 5'd0, 32'h0, 5'd3, 5'd5, 5'd3);
        rst_n = 1'b1;
        expect_out("rst_released", 0, 0, 0, 0);
        step(0, 5'd0, 32'h0, 5'd3, 5'd8, 5'd3);
        expect_out("rst_still0", 0, 0, 0, 0);

        // First write after release lands.
        step(1, 5'd3, 32'h0BADF00D, 5'd0, 5'd0, 5'd0);
        step(0, 5'd0, 32'h0, 5'd3, 5'd0, 5'd3);
        expect_out("post_rst_wr", 32'h0BADF00D, 0,
                   32'h0BADF00D, 16'd1);

        // Counter wrap: fresh reset, then 65536 writes to r1.
        step(0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b0;
        step(0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            step(1, 5'd1, 32'(i + 1), 5'd1, 5'd3, 5'd1);
            if (i == 65535) begin
                expect_out("wrap_last", 32'h00010000, 0,
                           32'h0000FFFF, 16'hFFFF);
            end
        end
        step(0, 5'd0, 32'h0, 5'd1, 5'd3, 5'd1);
        expect_out("wrap_after", 32'h00010000, 0,
                   32'h00010000, 16'h0000);

        // Drain the scoreboard with a bounded wait.
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0",
                     exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
